// File: rtl/iter_alu.sv
`default_nettype none
// ============================================================================
// Module      : iter_alu
// Description : Execution-stage ALU; single-cycle arithmetic/logic ops plus
//               iterative signed multiply/divide behind a start/busy/done port.
// Revision    : 1.0 - initial release
// ============================================================================
module iter_alu #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       operation,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             overflow,
    output logic             div_by_zero,
    output logic             illegal_op
);

    localparam logic [3:0] c_OP_ADD  = 4'b0000;
    localparam logic [3:0] c_OP_SUB  = 4'b0001;
    localparam logic [3:0] c_OP_MUL  = 4'b0010;
    localparam logic [3:0] c_OP_DIV  = 4'b0011;
    localparam logic [3:0] c_OP_MOVE = 4'b0100;
    localparam logic [3:0] c_OP_SWAP = 4'b0101;
    localparam logic [3:0] c_OP_AND  = 4'b0110;
    localparam logic [3:0] c_OP_OR   = 4'b0111;
    localparam logic [3:0] c_OP_ADDR = 4'b1000;
    localparam int         c_CW      = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [c_CW-1:0]    r_cnt;
    logic               r_is_div, r_neg_lo, r_neg_hi;
    logic [WIDTH-1:0]   r_acc, r_q, r_mop;
    logic               r_done, r_zero, r_ovf, r_dbz, r_ill;
    logic [WIDTH-1:0]   r_result, r_result_hi;

    logic               w_accept, w_is_mul, w_is_div, w_multi;
    logic [WIDTH-1:0]   w_abs_a, w_abs_b, w_add, w_sub;
    logic [WIDTH-1:0]   w_sc_res, w_sc_hi;
    logic               w_sc_ovf, w_sc_dbz, w_sc_ill;
    logic [WIDTH:0]     w_mul_sum, w_div_shift, w_div_diff;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_fix_res, w_fix_hi;

    assign w_accept = start && (r_state == S_IDLE);
    assign w_is_mul = (operation == c_OP_MUL);
    assign w_is_div = (operation == c_OP_DIV);
    assign w_multi  = w_accept && (w_is_mul || (w_is_div && (b != '0)));
    assign w_abs_a  = a[WIDTH-1] ? -a : a;
    assign w_abs_b  = b[WIDTH-1] ? -b : b;
    assign w_add    = a + b;
    assign w_sub    = a - b;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_multi) w_state_nxt = S_ITER;
            S_ITER:  if (r_cnt == '0) w_state_nxt = S_FIX;
            S_FIX:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_sc_res = '0;
        w_sc_hi  = '0;
        w_sc_ovf = 1'b0;
        w_sc_dbz = 1'b0;
        w_sc_ill = 1'b0;
        case (operation)
            c_OP_ADD, c_OP_ADDR: begin
                w_sc_res = w_add;
                w_sc_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (w_add[WIDTH-1] != a[WIDTH-1]);
            end
            c_OP_SUB: begin
                w_sc_res = w_sub;
                w_sc_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (w_sub[WIDTH-1] != a[WIDTH-1]);
            end
            c_OP_MUL:  w_sc_res = '0;
            // Only the divide-by-zero case of div ever completes through this path.
            c_OP_DIV: begin
                w_sc_res = '1;
                w_sc_hi  = a;
                w_sc_dbz = 1'b1;
            end
            c_OP_MOVE: w_sc_res = b;
            c_OP_SWAP: begin
                w_sc_res = b;
                w_sc_hi  = a;
            end
            c_OP_AND:  w_sc_res = a & b;
            c_OP_OR:   w_sc_res = a | b;
            default:   w_sc_ill = 1'b1;
        endcase
    end

    // Multiply: {r_acc, r_q} shifts right, r_q starts as |b|, r_mop = |a|.
    // Divide: restoring, r_acc = partial remainder, r_q = dividend/quotient.
    assign w_mul_sum   = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_mop} : '0);
    assign w_div_shift = {r_acc, r_q[WIDTH-1]};
    assign w_div_diff  = w_div_shift - {1'b0, r_mop};

    always_comb begin
        w_prod = {r_acc, r_q};
        if (r_neg_lo) w_prod = -w_prod;
        if (r_is_div) begin
            w_fix_res = r_neg_lo ? -r_q : r_q;
            w_fix_hi  = r_neg_hi ? -r_acc : r_acc;
        end else begin
            w_fix_res = w_prod[WIDTH-1:0];
            w_fix_hi  = w_prod[2*WIDTH-1:WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt       <= '0;
            r_is_div    <= 1'b0;
            r_neg_lo    <= 1'b0;
            r_neg_hi    <= 1'b0;
            r_acc       <= '0;
            r_q         <= '0;
            r_mop       <= '0;
            r_done      <= 1'b0;
            r_result    <= '0;
            r_result_hi <= '0;
            r_zero      <= 1'b0;
            r_ovf       <= 1'b0;
            r_dbz       <= 1'b0;
            r_ill       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_multi) begin
                        r_cnt    <= c_CW'(WIDTH - 1);
                        r_is_div <= w_is_div;
                        r_neg_lo <= a[WIDTH-1] ^ b[WIDTH-1];
                        r_neg_hi <= a[WIDTH-1];
                        r_acc    <= '0;
                        r_q      <= w_is_div ? w_abs_a : w_abs_b;
                        r_mop    <= w_is_div ? w_abs_b : w_abs_a;
                    end else if (w_accept) begin
                        r_done      <= 1'b1;
                        r_result    <= w_sc_res;
                        r_result_hi <= w_sc_hi;
                        r_zero      <= (w_sc_res == '0);
                        r_ovf       <= w_sc_ovf;
                        r_dbz       <= w_sc_dbz;
                        r_ill       <= w_sc_ill;
                    end
                end
                S_ITER: begin
                    r_cnt <= r_cnt - 1'b1;
                    if (r_is_div) begin
                        if (!w_div_diff[WIDTH]) begin
                            r_acc <= w_div_diff[WIDTH-1:0];
                            r_q   <= {r_q[WIDTH-2:0], 1'b1};
                        end else begin
                            r_acc <= w_div_shift[WIDTH-1:0];
                            r_q   <= {r_q[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        r_acc <= w_mul_sum[WIDTH:1];
                        r_q   <= {w_mul_sum[0], r_q[WIDTH-1:1]};
                    end
                end
                S_FIX: begin
                    r_done      <= 1'b1;
                    r_result    <= w_fix_res;
                    r_result_hi <= w_fix_hi;
                    r_zero      <= (w_fix_res == '0);
                    r_ovf       <= 1'b0;
                    r_dbz       <= 1'b0;
                    r_ill       <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign busy        = (r_state != S_IDLE);
    assign done        = r_done;
    assign result      = r_result;
    assign result_hi   = r_result_hi;
    assign zero        = r_zero;
    assign overflow    = r_ovf;
    assign div_by_zero = r_dbz;
    assign illegal_op  = r_ill;

endmodule
`default_nettype wire

// File: tb/tb_iter_alu.sv
`default_nettype none
// ============================================================================
// Module      : tb_iter_alu
// Description : Directed self-checking bench for iter_alu (WIDTH = 16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iter_alu;

    localparam logic [3:0] c_ADD  = 4'b0000;
    localparam logic [3:0] c_SUB  = 4'b0001;
    localparam logic [3:0] c_MUL  = 4'b0010;
    localparam logic [3:0] c_DIV  = 4'b0011;
    localparam logic [3:0] c_MOVE = 4'b0100;
    localparam logic [3:0] c_SWAP = 4'b0101;
    localparam logic [3:0] c_AND  = 4'b0110;
    localparam logic [3:0] c_OR   = 4'b0111;
    localparam logic [3:0] c_ADDR = 4'b1000;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [3:0]  operation;
    logic [15:0] a, b;
    logic        busy, done, zero, overflow, div_by_zero, illegal_op;
    logic [15:0] result, result_hi;

    int n_checks = 0;
    int n_fail   = 0;

    iter_alu #(.WIDTH(16)) dut (
        .clk(clk), .reset(reset), .start(start), .operation(operation),
        .a(a), .b(b), .busy(busy), .done(done), .result(result),
        .result_hi(result_hi), .zero(zero), .overflow(overflow),
        .div_by_zero(div_by_zero), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    // Presents one request for a single edge; returns #1 into cycle 1.
    task automatic issue(input logic [3:0] op, input logic [15:0] aa, input logic [15:0] bb);
        @(negedge clk);
        start = 1'b1; operation = op; a = aa; b = bb;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Advances until done (bounded); cyc is the cycle number reached, 1 = first after issue.
    task automatic wait_done(output int cyc);
        cyc = 1;
        while (done !== 1'b1 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; operation = '0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        n_checks++;
        if ({busy, done, result, result_hi, zero, overflow, div_by_zero, illegal_op} !== 38'd0) begin
            n_fail++;
            $display("FAIL reset: busy=%b done=%b res=%h hi=%h z=%b v=%b dz=%b il=%b, want all 0",
                     busy, done, result, result_hi, zero, overflow, div_by_zero, illegal_op);
        end
    endtask

    task automatic test_add_sub();
        issue(c_ADD, 16'h7FFF, 16'h0001);
        n_checks++;
        if ({done, busy, result, overflow, zero} !== {1'b1, 1'b0, 16'h8000, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL add_ovf: done=%b busy=%b res=%h v=%b z=%b, want 1 0 8000 1 0",
                     done, busy, result, overflow, zero);
        end
        @(posedge clk); #1;
        n_checks++;
        if ({done, result} !== {1'b0, 16'h8000}) begin
            n_fail++;
            $display("FAIL add_hold: done=%b res=%h, want 0 8000", done, result);
        end
        issue(c_SUB, 16'h1234, 16'h1234);
        n_checks++;
        if ({done, result, result_hi, zero, overflow} !== {1'b1, 16'h0000, 16'h0000, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL sub_zero: done=%b res=%h hi=%h z=%b v=%b, want 1 0000 0000 1 0",
                     done, result, result_hi, zero, overflow);
        end
        issue(c_ADDR, 16'h8000, 16'h8000);
        n_checks++;
        if ({done, result, zero, overflow} !== {1'b1, 16'h0000, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL addr_ovf: done=%b res=%h z=%b v=%b, want 1 0000 1 1",
                     done, result, zero, overflow);
        end
    endtask

    task automatic test_mul();
        int bad = 0;
        int cyc;
        issue(c_MUL, 16'hFFFD, 16'h0005);
        for (int c = 1; c <= 18; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            if (c < 18 && (done !== 1'b0 || busy !== 1'b1)) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL mul_busy: %0d cycles in 1..17 with done=1 or busy=0, want 0", bad);
        end
        n_checks++;
        if ({done, busy, result, result_hi, zero, overflow} !== {1'b1, 1'b0, 16'hFFF1, 16'hFFFF, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL mul_neg: cyc18 done=%b busy=%b res=%h hi=%h z=%b v=%b, want 1 0 fff1 ffff 0 0",
                     done, busy, result, result_hi, zero, overflow);
        end
        issue(c_MUL, 16'h4000, 16'h0004);
        wait_done(cyc);
        n_checks++;
        if (cyc != 18 || {result, result_hi, zero} !== {16'h0000, 16'h0001, 1'b1}) begin
            n_fail++;
            $display("FAIL mul_hi: cyc=%0d res=%h hi=%h z=%b, want 18 0000 0001 1",
                     cyc, result, result_hi, zero);
        end
    endtask

    task automatic test_div();
        int cyc;
        int bad = 0;
        issue(c_DIV, 16'hFFF9, 16'h0002);
        wait_done(cyc);
        n_checks++;
        if (cyc != 18 || {result, result_hi, div_by_zero} !== {16'hFFFD, 16'hFFFF, 1'b0}) begin
            n_fail++;
            $display("FAIL div_neg: cyc=%0d res=%h hi=%h dz=%b, want 18 fffd ffff 0",
                     cyc, result, result_hi, div_by_zero);
        end
        issue(c_DIV, 16'h8000, 16'hFFFF);
        wait_done(cyc);
        n_checks++;
        if (cyc != 18 || {result, result_hi, overflow, div_by_zero, zero} !== {16'h8000, 16'h0000, 3'b000}) begin
            n_fail++;
            $display("FAIL div_min: cyc=%0d res=%h hi=%h v=%b dz=%b z=%b, want 18 8000 0000 0 0 0",
                     cyc, result, result_hi, overflow, div_by_zero, zero);
        end
        issue(c_DIV, 16'h0042, 16'h0000);
        n_checks++;
        if ({done, busy, div_by_zero, result, result_hi} !== {1'b1, 1'b0, 1'b1, 16'hFFFF, 16'h0042}) begin
            n_fail++;
            $display("FAIL div_zero: done=%b busy=%b dz=%b res=%h hi=%h, want 1 0 1 ffff 0042",
                     done, busy, div_by_zero, result, result_hi);
        end
        repeat (3) begin
            @(posedge clk); #1;
            if (busy !== 1'b0 || done !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL div_zero_idle: %0d cycles with busy or done after completion, want 0", bad);
        end
    endtask

    task automatic test_logic_misc();
        issue(c_SWAP, 16'hAAAA, 16'h5555);
        n_checks++;
        if ({done, result, result_hi} !== {1'b1, 16'h5555, 16'hAAAA}) begin
            n_fail++;
            $display("FAIL swap: done=%b res=%h hi=%h, want 1 5555 aaaa", done, result, result_hi);
        end
        issue(c_AND, 16'hF0F0, 16'h3C3C);
        n_checks++;
        if ({result, result_hi, overflow} !== {16'h3030, 16'h0000, 1'b0}) begin
            n_fail++;
            $display("FAIL and: res=%h hi=%h v=%b, want 3030 0000 0", result, result_hi, overflow);
        end
        issue(c_OR, 16'hF0F0, 16'h3C3C);
        n_checks++;
        if (result !== 16'hFCFC) begin
            n_fail++;
            $display("FAIL or: res=%h, want fcfc", result);
        end
        issue(c_MOVE, 16'h1111, 16'hBEEF);
        n_checks++;
        if ({result, result_hi} !== {16'hBEEF, 16'h0000}) begin
            n_fail++;
            $display("FAIL move: res=%h hi=%h, want beef 0000", result, result_hi);
        end
        issue(4'b1111, 16'h1234, 16'h5678);
        n_checks++;
        if ({done, illegal_op, result, result_hi, zero} !== {1'b1, 1'b1, 16'h0000, 16'h0000, 1'b1}) begin
            n_fail++;
            $display("FAIL illegal: done=%b il=%b res=%h hi=%h z=%b, want 1 1 0000 0000 1",
                     done, illegal_op, result, result_hi, zero);
        end
    endtask

    task automatic test_busy_ignore();
        int n_done = 0;
        int at = 0;
        issue(c_MUL, 16'h0007, 16'h0003);
        for (int c = 2; c <= 25; c++) begin
            @(negedge clk);
            start = (c == 5); operation = c_ADD; a = 16'h0001; b = 16'h0001;
            @(posedge clk); #1;
            start = 1'b0;
            if (done === 1'b1) begin n_done++; at = c; end
        end
        n_checks++;
        if (n_done != 1 || at != 18 || {result, result_hi, illegal_op} !== {16'h0015, 16'h0000, 1'b0}) begin
            n_fail++;
            $display("FAIL busy_ignore: dones=%0d at=%0d res=%h hi=%h, want 1 18 0015 0000",
                     n_done, at, result, result_hi);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        issue(c_MUL, 16'h0002, 16'h0003);
        wait_done(cyc);
        n_checks++;
        if (cyc != 18 || result !== 16'h0006) begin
            n_fail++;
            $display("FAIL b2b_mul: cyc=%0d res=%h, want 18 0006", cyc, result);
        end
        issue(c_ADD, 16'h000A, 16'h0014);
        n_checks++;
        if ({done, busy, result, result_hi} !== {1'b1, 1'b0, 16'h001E, 16'h0000}) begin
            n_fail++;
            $display("FAIL b2b_add: done=%b busy=%b res=%h hi=%h, want 1 0 001e 0000",
                     done, busy, result, result_hi);
        end
        issue(c_SUB, 16'h0003, 16'h0005);
        n_checks++;
        if ({done, result, overflow} !== {1'b1, 16'hFFFE, 1'b0}) begin
            n_fail++;
            $display("FAIL b2b_sub: done=%b res=%h v=%b, want 1 fffe 0", done, result, overflow);
        end
    endtask

    task automatic test_reset_midop();
        int n_done = 0;
        issue(c_MUL, 16'hFFFD, 16'h0005);
        repeat (4) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        n_checks++;
        if ({busy, done, result, result_hi, zero} !== {1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_mid: busy=%b done=%b res=%h hi=%h z=%b, want 0 0 0000 0000 0",
                     busy, done, result, result_hi, zero);
        end
        issue(c_ADD, 16'h0002, 16'h0003);
        n_checks++;
        if ({done, result} !== {1'b1, 16'h0005}) begin
            n_fail++;
            $display("FAIL reset_then_add: done=%b res=%h, want 1 0005", done, result);
        end
        repeat (20) begin
            @(posedge clk); #1;
            if (done === 1'b1) n_done++;
        end
        n_checks++;
        if (n_done != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_stray: stray dones=%0d busy=%b, want 0 0", n_done, busy);
        end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_mul();
        test_div();
        test_logic_misc();
        test_busy_ignore();
        test_back_to_back();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
